// File: rtl/ulpi_reg_ctrl_pkg.sv
// Shared types and constants for the ULPI register access controller.
// Holds the controller state encoding and the register TX CMD prefixes.
package ulpi_reg_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TXCMD,
        ST_WDATA,
        ST_STP,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_RD_END,
        ST_WAIT_BUS,
        ST_ERR_STP,
        ST_DONE
    } state_t;

    localparam logic [1:0] TXCMD_REGW = 2'b10;
    localparam logic [1:0] TXCMD_REGR = 2'b11;

    function automatic logic [7:0] reg_txcmd(input logic write, input logic [5:0] addr);
        return {(write ? TXCMD_REGW : TXCMD_REGR), addr};
    endfunction

endpackage

// File: rtl/ulpi_timeout_cnt.sv
// Wait-state timeout counter: clears on request, counts while enabled and
// flags expiry on the cycle whose increment would reach TIMEOUT_CYCLES.
module ulpi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI PHY register read/write sequencer with bus-takeover retry, NXT/DIR
// timeout and forwarding of RX CMD bytes received while the bus is idle.
module ulpi_reg_ctrl
    import ulpi_reg_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       rx_cmd_valid,
    output logic [7:0] rx_cmd,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       wr_q;
    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic       err_q, err_set;
    logic [7:0] rdata_q;
    logic       dir_q;
    logic [7:0] rx_cmd_q;
    logic       rx_cmd_valid_q;
    logic       accept, link_oe, cnt_en, expired, rx_hit;

    assign req_ready = (state_q == ST_IDLE) & ~ulpi_dir;
    assign accept    = req_valid & req_ready;
    assign cnt_en    = (state_q == ST_TXCMD) | (state_q == ST_WDATA) |
                       (state_q == ST_RD_TURN) | (state_q == ST_RD_END);

    ulpi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (state_d != state_q),
        .en     (cnt_en),
        .expired(expired)
    );

    // A DIR rise while the link is driving means the PHY took the bus: abort.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE:     if (accept) state_d = ST_TXCMD;
            ST_TXCMD: begin
                if (ulpi_dir)      state_d = ST_WAIT_BUS;
                else if (ulpi_nxt) state_d = wr_q ? ST_WDATA : ST_RD_TURN;
                else if (expired) begin
                    state_d = ST_ERR_STP;
                    err_set = 1'b1;
                end
            end
            ST_WDATA: begin
                if (ulpi_dir)      state_d = ST_WAIT_BUS;
                else if (ulpi_nxt) state_d = ST_STP;
                else if (expired) begin
                    state_d = ST_ERR_STP;
                    err_set = 1'b1;
                end
            end
            ST_STP:      state_d = ST_DONE;
            ST_RD_TURN: begin
                if (ulpi_dir) state_d = ST_RD_DATA;
                else if (expired) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_RD_DATA:  state_d = ST_RD_END;
            ST_RD_END: begin
                if (!ulpi_dir) state_d = ST_DONE;
                else if (expired) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_WAIT_BUS: if (!ulpi_dir) state_d = ST_TXCMD;
            ST_ERR_STP:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        link_oe       = 1'b0;
        ulpi_data_out = 8'h00;
        ulpi_stp      = 1'b0;
        unique case (state_q)
            ST_TXCMD: begin
                link_oe       = 1'b1;
                ulpi_data_out = reg_txcmd(wr_q, addr_q);
            end
            ST_WDATA: begin
                link_oe       = 1'b1;
                ulpi_data_out = wdata_q;
            end
            ST_STP, ST_ERR_STP: begin
                link_oe  = 1'b1;
                ulpi_stp = 1'b1;
            end
            default: ;
        endcase
    end

    assign ulpi_data_oe = link_oe & ~ulpi_dir;
    assign rsp_valid    = (state_q == ST_DONE);
    assign rsp_err      = rsp_valid & err_q;
    assign rsp_rdata    = rdata_q;
    assign rx_cmd_valid = rx_cmd_valid_q;
    assign rx_cmd       = rx_cmd_q;
    assign busy         = (state_q != ST_IDLE);

    // RX CMDs arrive after the DIR turnaround cycle and carry NXT low.
    assign rx_hit = ((state_q == ST_IDLE) | (state_q == ST_WAIT_BUS)) &
                    ulpi_dir & dir_q & ~ulpi_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            dir_q          <= 1'b0;
            rx_cmd_q       <= '0;
            rx_cmd_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= ulpi_dir;
            rx_cmd_valid_q <= rx_hit;
            if (rx_hit) rx_cmd_q <= ulpi_data_in;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_RD_DATA) rdata_q <= ulpi_data_in;
        end
    end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl: write, read, abort/retry, timeout,
// reset mid-transfer and idle RX CMD capture with hand-computed expectations.
module tb_ulpi_reg_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       req_valid, req_ready, req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;
    logic [7:0] ulpi_data_in, ulpi_data_out;
    logic       ulpi_data_oe, ulpi_dir, ulpi_nxt, ulpi_stp, busy;

    int checks   = 0;
    int failures = 0;
    int pulses;

    always #5 clk = ~clk;

    ulpi_reg_ctrl #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .rx_cmd_valid (rx_cmd_valid),
        .rx_cmd       (rx_cmd),
        .ulpi_data_in (ulpi_data_in),
        .ulpi_data_out(ulpi_data_out),
        .ulpi_data_oe (ulpi_data_oe),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_stp     (ulpi_stp),
        .busy         (busy)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apply_stimulus(input logic valid, input logic write,
                                  input logic [5:0] addr, input logic [7:0] wdata);
        req_valid = valid;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        nrst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 6'h00, 8'h00);
        ulpi_data_in = 8'h00;
        ulpi_dir     = 1'b0;
        ulpi_nxt     = 1'b0;
        repeat (3) next_cycle();
        settle();
        check_output("rst_data_out", ulpi_data_out, 8'h00);
        check_output("rst_oe", ulpi_data_oe, 1'b0);
        check_output("rst_stp", ulpi_stp, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
        check_output("rst_rxcmd", {rx_cmd_valid, rx_cmd}, 9'h000);
        nrst = 1'b1;

        // Write 0x45 to 0x04, NXT on the 2nd TXCMD and 1st WDATA cycles.
        next_cycle();
        apply_stimulus(1'b1, 1'b1, 6'h04, 8'h45);
        settle();
        check_output("wr_ready", req_ready, 1'b1);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check_output("wr_txcmd1", {ulpi_data_oe, ulpi_data_out}, 9'h184);
        check_output("wr_busy", busy, 1'b1);
        next_cycle();
        ulpi_nxt = 1'b1;
        settle();
        check_output("wr_txcmd2", {ulpi_data_oe, ulpi_data_out}, 9'h184);
        next_cycle();
        settle();
        check_output("wr_wdata", {ulpi_data_oe, ulpi_data_out}, 9'h145);
        next_cycle();
        ulpi_nxt = 1'b0;
        settle();
        check_output("wr_stp", {ulpi_stp, ulpi_data_oe, ulpi_data_out}, 10'h300);
        check_output("wr_stp_no_rsp", rsp_valid, 1'b0);
        next_cycle();
        settle();
        check_output("wr_done", {rsp_valid, rsp_err, ulpi_stp}, 3'b100);
        next_cycle();
        settle();
        check_output("wr_idle", {rsp_valid, busy}, 2'b00);

        // Read 0x00: NXT on first TXCMD, DIR turnaround, data 0x24, DIR low.
        apply_stimulus(1'b1, 1'b0, 6'h00, 8'h00);
        next_cycle();
        req_valid = 1'b0;
        ulpi_nxt  = 1'b1;
        settle();
        check_output("rd_txcmd", {ulpi_data_oe, ulpi_data_out}, 9'h1C0);
        next_cycle();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        settle();
        check_output("rd_turn_oe", ulpi_data_oe, 1'b0);
        next_cycle();
        ulpi_data_in = 8'h24;
        settle();
        check_output("rd_data_oe", ulpi_data_oe, 1'b0);
        next_cycle();
        ulpi_dir     = 1'b0;
        ulpi_data_in = 8'h00;
        settle();
        check_output("rd_end", {ulpi_data_oe, rsp_valid}, 2'b00);
        next_cycle();
        settle();
        check_output("rd_done", {rsp_valid, rsp_err, rsp_rdata}, 10'h224);
        check_output("rd_no_rxcmd", rx_cmd_valid, 1'b0);
        next_cycle();
        settle();
        check_output("rd_idle", {rsp_valid, busy}, 2'b00);

        // Write to 0x0A aborted by the PHY taking the bus with RX CMD 0x4D.
        apply_stimulus(1'b1, 1'b1, 6'h0A, 8'h5A);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check_output("ab_txcmd", {ulpi_data_oe, ulpi_data_out}, 9'h18A);
        next_cycle();
        ulpi_dir     = 1'b1;
        ulpi_data_in = 8'h4D;
        settle();
        check_output("ab_oe_drop", ulpi_data_oe, 1'b0);
        next_cycle();
        settle();
        check_output("ab_wait_busy", {busy, ulpi_data_oe, ulpi_stp}, 3'b100);
        next_cycle();
        settle();
        check_output("ab_rxcmd", {rx_cmd_valid, rx_cmd}, 9'h14D);
        next_cycle();
        ulpi_dir     = 1'b0;
        ulpi_data_in = 8'h00;
        settle();
        check_output("ab_wait_oe", ulpi_data_oe, 1'b0);
        next_cycle();
        ulpi_nxt = 1'b1;
        settle();
        check_output("ab_reissue", {ulpi_data_oe, ulpi_data_out}, 9'h18A);
        check_output("ab_rxcmd_end", rx_cmd_valid, 1'b0);
        next_cycle();
        settle();
        check_output("ab_wdata", {ulpi_data_oe, ulpi_data_out}, 9'h15A);
        next_cycle();
        ulpi_nxt = 1'b0;
        settle();
        check_output("ab_stp", {ulpi_stp, ulpi_data_out}, 9'h100);
        next_cycle();
        settle();
        check_output("ab_done", {rsp_valid, rsp_err}, 2'b10);

        // Read of 0x15 with NXT held low: 255 TXCMD cycles, then STP, then error.
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 6'h15, 8'h00);
        next_cycle();
        req_valid = 1'b0;
        for (int i = 1; i < 255; i++) next_cycle();
        settle();
        check_output("to_last_txcmd", {ulpi_stp, ulpi_data_oe, ulpi_data_out}, 10'h1D5);
        next_cycle();
        settle();
        check_output("to_err_stp", {ulpi_stp, ulpi_data_oe, ulpi_data_out}, 10'h300);
        check_output("to_err_stp_rsp", rsp_valid, 1'b0);
        next_cycle();
        settle();
        check_output("to_done", {rsp_valid, rsp_err, rsp_rdata}, 10'h324);
        next_cycle();
        settle();
        check_output("to_idle", {rsp_valid, rsp_err, busy}, 3'b000);

        // Asynchronous reset while in WDATA.
        apply_stimulus(1'b1, 1'b1, 6'h01, 8'h11);
        next_cycle();
        req_valid = 1'b0;
        ulpi_nxt  = 1'b1;
        next_cycle();
        ulpi_nxt = 1'b0;
        settle();
        check_output("rm_wdata", {ulpi_data_oe, ulpi_data_out}, 9'h111);
        nrst = 1'b0;
        #1;
        check_output("rm_async", {ulpi_data_oe, ulpi_stp, busy}, 3'b000);
        next_cycle();
        settle();
        check_output("rm_no_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
        next_cycle();
        nrst = 1'b1;
        settle();
        check_output("rm_ready", {req_ready, busy}, 2'b10);

        // Idle RX CMD: DIR high for 4 cycles with data 0x01, request pending.
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 6'h02, 8'h00);
        ulpi_dir     = 1'b1;
        ulpi_data_in = 8'h01;
        pulses       = 0;
        settle();
        check_output("ix_d1_valid", rx_cmd_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                next_cycle();
                if (i == 4) begin
                    req_valid    = 1'b0;
                    ulpi_dir     = 1'b0;
                    ulpi_data_in = 8'h00;
                end
                settle();
            end
            if (rx_cmd_valid) pulses++;
            if (i < 4) check_output($sformatf("ix_ready_%0d", i), {req_ready, busy}, 2'b00);
        end
        check_output("ix_pulses", pulses, 3);
        check_output("ix_rxcmd", rx_cmd, 8'h01);
        check_output("ix_not_accepted", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
